// File: rtl/fsm_pkg.sv
// Shared types and sizes for the exec sequencer and the result-select stage.
package fsm_pkg;

  localparam int unsigned DataWidth         = 8;
  localparam int unsigned ExecCyclesDefault = 4;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_LOAD = 2'd1,
    STATE_EXEC = 2'd2,
    STATE_DONE = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/exec_cycle_counter.sv
// Clear/enable cycle counter; o_tc_c flags the last EXEC cycle (count == Terminal-1).
module exec_cycle_counter #(
  parameter int unsigned Terminal = 4,
  parameter int unsigned CntW     = $clog2(Terminal + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  logic [CntW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CntW'(1);
    end
  end

  assign o_tc_c = (r_count == CntW'(Terminal - 1));

endmodule

// File: rtl/exec_sequencer.sv
// Control stage feeding the result-select stage: IDLE -> LOAD -> EXEC(xExecCycles) -> DONE.
// Optional abort of LOAD/EXEC is built only when EXEC_SEQ_ABORT_EN is defined.
module exec_sequencer
  import fsm_pkg::*;
#(
  parameter int unsigned ExecCycles = ExecCyclesDefault
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_valid_i,
  output logic                 start_ready_o,
  input  logic [DataWidth-1:0] start_d0_i,
  input  logic [DataWidth-1:0] start_d1_i,
  input  logic                 abort_i,
  output fsm_state_e           state_o,
  output logic                 valid_o,
  output logic [DataWidth-1:0] d0_o,
  output logic [DataWidth-1:0] d1_o,
  input  logic [DataWidth-1:0] result_i,
  output logic [DataWidth-1:0] result_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i
);

  fsm_state_e           r_state;
  logic                 r_valid;
  logic [DataWidth-1:0] r_d0;
  logic [DataWidth-1:0] r_d1;
  logic [DataWidth-1:0] r_result;
  logic                 r_result_valid;

  logic w_start_fire;
  logic w_abort;
  logic w_tc;

`ifdef EXEC_SEQ_ABORT_EN
  assign w_abort = abort_i;
`else
  logic w_unused_abort;
  assign w_unused_abort = abort_i;
  assign w_abort        = 1'b0;
`endif

  // A pending result must be drained (possibly this same cycle) before a new start.
  assign start_ready_o = (r_state == STATE_IDLE) && (!r_result_valid || result_ready_i);
  assign w_start_fire  = start_valid_i && start_ready_o;

  exec_cycle_counter #(
    .Terminal (ExecCycles)
  ) u_counter (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clr   (r_state != STATE_EXEC),
    .i_en    (r_state == STATE_EXEC),
    .o_tc_c  (w_tc)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= STATE_IDLE;
      r_valid        <= 1'b0;
      r_d0           <= '0;
      r_d1           <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      if (r_result_valid && result_ready_i) begin
        r_result_valid <= 1'b0;
      end
      case (r_state)
        STATE_IDLE: begin
          if (w_start_fire) begin
            r_d0    <= start_d0_i;
            r_d1    <= start_d1_i;
            r_state <= STATE_LOAD;
          end
        end
        STATE_LOAD: begin
          if (w_abort) begin
            r_state <= STATE_IDLE;
          end else begin
            r_state <= STATE_EXEC;
            r_valid <= 1'b1;
          end
        end
        STATE_EXEC: begin
          // Abort wins over the terminal-count exit.
          if (w_abort || w_tc) begin
            r_valid <= 1'b0;
            r_state <= w_abort ? STATE_IDLE : STATE_DONE;
          end
        end
        STATE_DONE: begin
          r_result       <= result_i;
          r_result_valid <= 1'b1;
          r_state        <= STATE_IDLE;
        end
        default: r_state <= STATE_IDLE;
      endcase
    end
  end

  assign state_o        = r_state;
  assign valid_o        = r_valid;
  assign d0_o           = r_d0;
  assign d1_o           = r_d1;
  assign result_o       = r_result;
  assign result_valid_o = r_result_valid;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer with a behavioural result-select stage attached.
module tb_exec_sequencer;
  import fsm_pkg::*;

  localparam int unsigned EC = 4;

  logic       clk;
  logic       rst_n;
  logic       s_valid, s_ready;
  logic [7:0] s_d0, s_d1;
  logic       abort;
  fsm_state_e state;
  logic       valid;
  logic [7:0] d0, d1, res_i, res_o;
  logic       res_valid, res_ready;

  logic       b_valid, b_ready;
  logic [7:0] b_d0, b_d1;
  fsm_state_e b_state;
  logic       b_vo;
  logic [7:0] b_q0, b_q1, b_res_i, b_res_o;
  logic       b_res_valid;

  int         n_checks;
  int         n_pass;
  logic [7:0] sb_q[$];

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    int         hold;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[5];

  // Result-select stage: FF while not producing, d1 during EXEC, d0&d1 in DONE.
  function automatic logic [7:0] rsel(input fsm_state_e s, input logic v,
                                      input logic [7:0] a, input logic [7:0] b);
    case (s)
      STATE_LOAD: return 8'hFF;
      STATE_EXEC: return v ? b : 8'hFF;
      STATE_DONE: return a & b;
      default:    return 8'h00;
    endcase
  endfunction

  assign res_i   = rsel(state, valid, d0, d1);
  assign b_res_i = rsel(b_state, b_vo, b_q0, b_q1);

  exec_sequencer #(.ExecCycles(EC)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_valid_i  (s_valid),
    .start_ready_o  (s_ready),
    .start_d0_i     (s_d0),
    .start_d1_i     (s_d1),
    .abort_i        (abort),
    .state_o        (state),
    .valid_o        (valid),
    .d0_o           (d0),
    .d1_o           (d1),
    .result_i       (res_i),
    .result_o       (res_o),
    .result_valid_o (res_valid),
    .result_ready_i (res_ready)
  );

  exec_sequencer #(.ExecCycles(1)) dut1 (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_valid_i  (b_valid),
    .start_ready_o  (b_ready),
    .start_d0_i     (b_d0),
    .start_d1_i     (b_d1),
    .abort_i        (1'b0),
    .state_o        (b_state),
    .valid_o        (b_vo),
    .d0_o           (b_q0),
    .d1_o           (b_q1),
    .result_i       (b_res_i),
    .result_o       (b_res_o),
    .result_valid_o (b_res_valid),
    .result_ready_i (1'b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chkst(input string name, input fsm_state_e act, input fsm_state_e exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %s expected %s", name, act.name(), exp.name());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer operands until accepted (bounded); returns one step after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_d0    = a;
    s_d1    = b;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) sb_q.push_back(exp);
    else begin
      n_checks++;
      $display("FAIL start_timeout: start_ready_o never rose for %h/%h", a, b);
    end
    tick();
    s_valid = 1'b0;
  endtask

  // Walk LOAD, EXEC x EC, DONE, then the result cycle on the main DUT.
  task automatic follow_main(input logic [7:0] d1v, input logic [7:0] resv);
    chkst("load_state", state, STATE_LOAD);
    chk8("load_rsel", res_i, 8'hFF);
    chk1("load_valid", valid, 1'b0);
    for (int k = 0; k < int'(EC); k++) begin
      tick();
      chkst("exec_state", state, STATE_EXEC);
      chk8("exec_rsel", res_i, d1v);
      chk1("exec_valid", valid, 1'b1);
    end
    tick();
    chkst("done_state", state, STATE_DONE);
    chk8("done_rsel", res_i, resv);
    chk1("done_valid", valid, 1'b0);
    tick();
    chk1("result_valid", res_valid, 1'b1);
    chk8("result_value", res_o, resv);
    chkst("result_state", state, STATE_IDLE);
  endtask

  initial begin
    logic [7:0] bd0[2];
    logic [7:0] bd1[2];
    n_checks  = 0;
    n_pass    = 0;
    vecs[0]   = '{8'h3C, 8'hA5, 0, 8'h24};
    vecs[1]   = '{8'hC3, 8'h5A, 2, 8'h42};
    vecs[2]   = '{8'hF3, 8'h3F, 5, 8'h33};
    vecs[3]   = '{8'h81, 8'hC3, 1, 8'h81};
    vecs[4]   = '{8'hAA, 8'h55, 0, 8'h00};
    bd0[0]    = 8'hF3; bd1[0] = 8'h3F;
    bd0[1]    = 8'hF0; bd1[1] = 8'h0F;

    rst_n     = 1'b0;
    s_valid   = 1'b0; s_d0 = 8'h00; s_d1 = 8'h00;
    abort     = 1'b0;
    res_ready = 1'b1;
    b_valid   = 1'b0; b_d0 = 8'h00; b_d1 = 8'h00;

    // Scoreboard: pop and compare at each result handshake, sampled mid-cycle.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && res_valid && res_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL sb_unexpected: result %h with empty scoreboard", res_o);
          end else begin
            chk8("sb_result", res_o, sb_q.pop_front());
          end
        end
      end
    join_none

    #12;
    chkst("rst_state", state, STATE_IDLE);
    chk1("rst_valid", valid, 1'b0);
    chk1("rst_result_valid", res_valid, 1'b0);
    chk8("rst_d0", d0, 8'h00);
    chk8("rst_d1", d1, 8'h00);
    chk8("rst_result", res_o, 8'h00);
    chk1("rst_start_ready", s_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table-driven operations with optional result backpressure.
    foreach (vecs[i]) begin
      res_ready = (vecs[i].hold == 0);
      issue(vecs[i].d0, vecs[i].d1, vecs[i].exp);
      follow_main(vecs[i].d1, vecs[i].exp);
      for (int h = 0; h < vecs[i].hold; h++) begin
        chk8("bp_hold_result", res_o, vecs[i].exp);
        chk1("bp_hold_valid", res_valid, 1'b1);
        chk1("bp_hold_start_ready", s_ready, 1'b0);
        tick();
      end
      res_ready = 1'b1;
      tick();
      chk1("consumed", res_valid, 1'b0);
    end

    // Backpressure with a waiting start accepted in the release cycle.
    res_ready = 1'b0;
    issue(8'h5A, 8'hC3, 8'h42);
    follow_main(8'hC3, 8'h42);
    s_valid = 1'b1; s_d0 = 8'h0F; s_d1 = 8'hFF;
    for (int h = 0; h < 5; h++) begin
      chk1("bp2_start_ready", s_ready, 1'b0);
      chk8("bp2_result", res_o, 8'h42);
      chkst("bp2_state", state, STATE_IDLE);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk1("bp2_release_ready", s_ready, 1'b1);
    sb_q.push_back(8'h0F);
    tick();
    s_valid = 1'b0;
    chk1("bp2_result_cleared", res_valid, 1'b0);
    chk8("bp2_new_d0", d0, 8'h0F);
    follow_main(8'hFF, 8'h0F);
    tick();

    // Abort in the second EXEC cycle.
    issue(8'h3C, 8'hA5, 8'h24);
    chkst("ab_load", state, STATE_LOAD);
    tick();
    tick();
    chkst("ab_exec2", state, STATE_EXEC);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`ifdef EXEC_SEQ_ABORT_EN
    chkst("ab_idle", state, STATE_IDLE);
    chk1("ab_valid", valid, 1'b0);
    void'(sb_q.pop_back());
    for (int k = 0; k < 6; k++) begin
      chk1("ab_no_result", res_valid, 1'b0);
      tick();
    end
`else
    chkst("ab_ignored_exec3", state, STATE_EXEC);
    tick();
    chkst("ab_ignored_exec4", state, STATE_EXEC);
    tick();
    chkst("ab_ignored_done", state, STATE_DONE);
    chk8("ab_ignored_rsel", res_i, 8'h24);
    tick();
    chk1("ab_ignored_rvalid", res_valid, 1'b1);
    chk8("ab_ignored_result", res_o, 8'h24);
    tick();
`endif

    // Reset dropped mid-EXEC, then a normal operation.
    issue(8'hAA, 8'hFF, 8'hAA);
    tick();
    tick();
    chkst("mr_exec", state, STATE_EXEC);
    #2;
    rst_n = 1'b0;
    #1;
    chkst("mr_state", state, STATE_IDLE);
    chk1("mr_valid", valid, 1'b0);
    chk8("mr_d0", d0, 8'h00);
    chk8("mr_d1", d1, 8'h00);
    chk8("mr_result", res_o, 8'h00);
    chk1("mr_result_valid", res_valid, 1'b0);
    void'(sb_q.pop_back());
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk1("mr_no_result", res_valid, 1'b0);
    end
    issue(8'h81, 8'hC3, 8'h81);
    follow_main(8'hC3, 8'h81);
    tick();

    // ExecCycles=1 boundary on the second instance.
    for (int i = 0; i < 2; i++) begin
      b_valid = 1'b1; b_d0 = bd0[i]; b_d1 = bd1[i];
      #1;
      chk1("b1_start_ready", b_ready, 1'b1);
      tick();
      b_valid = 1'b0;
      chkst("b1_load", b_state, STATE_LOAD);
      tick();
      chkst("b1_exec", b_state, STATE_EXEC);
      chk8("b1_exec_rsel", b_res_i, bd1[i]);
      tick();
      chkst("b1_done", b_state, STATE_DONE);
      chk8("b1_done_rsel", b_res_i, bd0[i] & bd1[i]);
      tick();
      chk1("b1_result_valid", b_res_valid, 1'b1);
      chk8("b1_result", b_res_o, bd0[i] & bd1[i]);
      tick();
    end

    chk8("sb_drained", 8'(sb_q.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

- Upstream control stage for the combinational result-select stage.
- Accepts an operand pair over a valid/ready handshake and steps through IDLE → LOAD → EXEC → DONE, driving `state_o`, `valid_o`, `d0_o` and `d1_o` into the result-select stage.
- Captures that stage's `result_i` in DONE and offers it downstream over a second valid/ready handshake.

## Interface
Parameters:
- `ExecCycles`, default 4: number of cycles spent in EXEC; legal range 1..255.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk_i`  input  1  sole clock, rising edge.
- `rst_ni`  input  1  asynchronous, active-low reset.
- `start_valid_i`  input  1  operand pair offered.
- `start_ready_o`  output  1  sequencer accepts operands.
- `start_d0_i`  input  8  operand 0.
- `start_d1_i`  input  8  operand 1.
- `abort_i`  input  1  cancel the operation in flight (see Configuration).
- `state_o`  output  `fsm_state_e`  current state, to the result-select stage.
- `valid_o`  output  1  data-valid qualifier, to the result-select stage.
- `d0_o`, `d1_o`  output  8 each  registered operands, to the result-select stage.
- `result_i`  input  8  result from the result-select stage.
- `result_o`  output  8  captured result.
- `result_valid_o`  output  1  result available.
- `result_ready_i`  input  1  consumer accepts the result.

## Operation
- Reset value of every output:
  - `state_o` = STATE_IDLE.
  - `valid_o`, `result_valid_o` = 0.
  - `d0_o`, `d1_o`, `result_o` = 8'h00.
  - Internal EXEC counter = 0.
  - `start_ready_o` = 1, since it follows combinationally from IDLE with no pending result.
- `start_ready_o` = (state == IDLE) && (!result_valid_o || result_ready_i).
- Start handshake is `start_valid_i && start_ready_o` at a clock edge. It captures `start_d0_i`/`start_d1_i` into `d0_o`/`d1_o` and moves to LOAD. Operands hold until the next accepted start.
- IDLE: `valid_o` = 0.
- LOAD: one cycle, `valid_o` = 0, so the result-select stage outputs 8'hFF. Moves to EXEC and clears the counter.
- EXEC: `valid_o` = 1. The counter increments each cycle. The state moves to DONE on the cycle the counter equals ExecCycles−1.
- DONE: one cycle, `valid_o` = 0. At the exit edge, `result_i` is registered into `result_o`, `result_valid_o` is set, and the state moves to IDLE.
- Result handshake:
  - `result_valid_o` stays high and `result_o` stays stable until `result_valid_o && result_ready_i`, which clears `result_valid_o`.
  - A start is accepted in the same cycle a pending result is consumed.
- Abort:
  - `abort_i` in LOAD or EXEC forces IDLE on the next edge, with `valid_o` = 0. No result is produced and `result_valid_o` is unchanged.
  - `abort_i` in IDLE or DONE is ignored.
  - Abort has priority over the EXEC→DONE transition in the same cycle.
- An overlapping result cannot occur: a new start requires the previous result to be consumed or consumed that cycle.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronously). No result is emitted.

## Timing
- Start accepted at edge 0:
  - LOAD in cycle 1.
  - EXEC in cycles 2..1+ExecCycles.
  - DONE in cycle 2+ExecCycles.
  - `result_valid_o` high from cycle 3+ExecCycles.
- Latency from start to result is ExecCycles+3 cycles. With ExecCycles=4, `result_valid_o` rises at cycle 7.
- Back-to-back throughput with `result_ready_i` held at 1 is one operation per ExecCycles+3 cycles.
- All outputs are registered except `start_ready_o`.
- `result_i` is sampled only in DONE. The result-select stage is combinational, so it needs no extra wait.

## Configuration
- Macro `EXEC_SEQ_ABORT_EN`.
- Defined: `abort_i` behaves as specified above.
- Undefined: the `abort_i` port remains but is ignored, every accepted start runs to DONE, and the abort logic is not synthesised.

## Structure
- Shared package `fsm_pkg`:
  - `fsm_state_e` (IDLE=0, LOAD=1, EXEC=2, DONE=3), shared with the result-select stage.
  - `DataWidth = 8`.
  - `ExecCyclesDefault = 4`.
- Sub-module `exec_cycle_counter`: a clear/enable counter of width $clog2(ExecCycles+1), with a terminal-count output.
- The FSM, operand registers and result register stay in `exec_sequencer`.

## Test plan
- Basic flow (ExecCycles=4, result-select stage attached, `result_ready_i`=1): start d0=8'h3C, d1=8'hA5 at cycle 0.
  - Required: `state_o` sequence IDLE, LOAD, EXEC×4, DONE.
  - Required: `result_i` reads 8'hFF in LOAD, 8'hA5 in EXEC, 8'h24 in DONE.
  - Required: `result_o`=8'h24 with `result_valid_o`=1 at cycle 7.
- Backpressure: hold `result_ready_i`=0 for 5 cycles after the result.
  - Required: `result_o` stays stable and `start_ready_o`=0 throughout.
  - Required: in the cycle `result_ready_i` rises, both the pending result and a new start are accepted.
- Abort: with the macro defined, assert `abort_i` in the second EXEC cycle.
  - Required: IDLE on the next edge and `result_valid_o` stays 0.
  - Required: with the macro undefined, the same stimulus gives the full flow.
- Boundary: ExecCycles=1, start d0=8'hF0, d1=8'h0F.
  - Required: exactly one EXEC cycle.
  - Required: `result_o`=8'h00 valid at cycle 4.
- Reset mid-EXEC: drop `rst_ni` during EXEC.
  - Required: outputs take reset values immediately.
  - Required: no result is emitted, and the next start runs normally.
